// File: rtl/avalon_accum_pkg.sv
// Shared constants for the Avalon-MM accumulator slave: register word
// addresses, CTRL/STATUS bit positions and the default accumulator width.
package avalon_accum_pkg;

    localparam int ACC_W_DEFAULT = 16;

    localparam logic [1:0] ADDR_ACC    = 2'd0;
    localparam logic [1:0] ADDR_SW     = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_LED_SRC = 0;
    localparam int CTRL_IRQ_EN  = 1;

    localparam int STAT_OVF   = 0;
    localparam int STAT_PRESS = 1;

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner.
// The raw key is brought into the clock domain through two flops. A counter
// measures how long the synchronized level has been stable. The debounced
// level follows it only after DEBOUNCE_CYCLES stable cycles. A one-cycle
// press pulse is produced on a debounced released->pressed transition.
// Releasing the key produces no event. All state resets to "released".
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta;
    logic             key_sync;
    logic             key_last;
    logic             key_deb;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button, idling at released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    // Stability counter, debounced level and press pulse generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_last <= 1'b1;
            key_deb  <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            press    <= 1'b0;
            key_last <= key_sync;
            if (key_sync != key_last) begin
                cnt <= '0;
            end else if (key_sync != key_deb) begin
                if (cnt == CNT_LAST) begin
                    key_deb <= key_sync;
                    cnt     <= '0;
                    press   <= key_deb & ~key_sync;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/avalon_accum_slave.sv
// Avalon-MM slave with a push-button accumulator.
// Every debounced key press adds the synchronized switch value to ACC.
// Registers: ACC (0), SW (1), CTRL (2), STATUS (3, write-1-to-clear).
// Reads have a fixed one-cycle latency and never stall.
// Optional build macro ACCUM_SAT_EN: when it is defined, an overflowing add
// clamps ACC to all ones instead of wrapping. OVF is set in both modes.
module avalon_accum_slave
    import avalon_accum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACC_W           = ACC_W_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    input  logic        key_n,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        irq
);

    localparam int SUM_W = ACC_W + 1;

    logic [7:0]       sw_meta;
    logic [7:0]       sw_sync;
    logic             press_pulse;
    logic [ACC_W-1:0] acc;
    logic [1:0]       ctrl;
    logic [1:0]       status;

    logic [SUM_W-1:0] acc_sum;
    logic             acc_carry;
    logic [ACC_W-1:0] acc_added;
    logic             wr_acc;
    logic             wr_ctrl;
    logic             wr_status;
    logic [1:0]       status_set;
    logic [1:0]       status_clr;
    logic [1:0]       status_next;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Upper write-data bits beyond the widest register are intentionally ignored
    assign unused_wdata = ^avs_writedata;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (CLK),
        .rst   (RESET),
        .key_n (key_n),
        .press (press_pulse)
    );

    // Two-flop synchronizer for the asynchronous switch bank
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Add result, write decode, STATUS set/clear merge and read mux
    always_comb begin
        acc_sum   = {1'b0, acc} + SUM_W'(sw_sync);
        acc_carry = acc_sum[ACC_W];
`ifdef ACCUM_SAT_EN
        acc_added = acc_carry ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
        acc_added = acc_sum[ACC_W-1:0];
`endif
        wr_acc    = avs_write && (avs_address == ADDR_ACC);
        wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
        wr_status = avs_write && (avs_address == ADDR_STATUS);

        status_set             = 2'b00;
        status_set[STAT_PRESS] = press_pulse;
        status_set[STAT_OVF]   = press_pulse & acc_carry & ~wr_acc;
        status_clr             = wr_status ? avs_writedata[1:0] : 2'b00;
        status_next            = (status & ~status_clr) | status_set;

        rd_mux = '0;
        case (avs_address)
            ADDR_ACC:    rd_mux = 32'(acc);
            ADDR_SW:     rd_mux = 32'(sw_sync);
            ADDR_CTRL:   rd_mux = 32'(ctrl);
            ADDR_STATUS: rd_mux = 32'(status);
            default:     rd_mux = '0;
        endcase
    end

    // Register file: a bus write to ACC takes priority over a key-driven add
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc    <= '0;
            ctrl   <= '0;
            status <= '0;
        end else begin
            if (wr_acc) begin
                acc <= avs_writedata[ACC_W-1:0];
            end else if (press_pulse) begin
                acc <= acc_added;
            end
            if (wr_ctrl) begin
                ctrl <= avs_writedata[1:0];
            end
            status <= status_next;
        end
    end

    // One-cycle read response; data is forced to zero when not valid
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            avs_readdata      <= avs_read ? rd_mux : 32'd0;
        end
    end

    // Registered LED source select and level interrupt
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            led <= '0;
            irq <= 1'b0;
        end else begin
            led <= ctrl[CTRL_LED_SRC] ? sw_sync : acc[7:0];
            irq <= ctrl[CTRL_IRQ_EN] & (status[STAT_PRESS] | status[STAT_OVF]);
        end
    end

endmodule

// File: tb/tb_avalon_accum_slave.sv
// Self-checking bench for avalon_accum_slave (DEBOUNCE_CYCLES=4, ACC_W=16).
// A behavioural model tracks ACC/CTRL/STATUS with plain integer arithmetic.
// Directed scenarios and randomized press sequences are checked against it.
module tb_avalon_accum_slave;

    localparam int DEB = 4;
    localparam int AW  = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        key_n = 1'b1;
    logic [7:0]  sw = 8'd0;
    logic [7:0]  led;
    logic        irq;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    int unsigned model_acc   = 0;
    bit          model_ovf   = 1'b0;
    bit          model_press = 1'b0;
    bit [1:0]    model_ctrl  = 2'b00;

    avalon_accum_slave #(
        .DEBOUNCE_CYCLES (DEB),
        .ACC_W           (AW)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .key_n             (key_n),
        .sw                (sw),
        .led               (led),
        .irq               (irq)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        model_acc   = 0;
        model_ovf   = 1'b0;
        model_press = 1'b0;
        model_ctrl  = 2'b00;
    endfunction

    function automatic void model_add(input logic [7:0] sw_val);
        int unsigned sum;
        sum = model_acc + int'(sw_val);
        model_press = 1'b1;
        if (sum >= (1 << AW)) begin
            model_ovf = 1'b1;
`ifdef ACCUM_SAT_EN
            model_acc = (1 << AW) - 1;
`else
            model_acc = sum - (1 << AW);
`endif
        end else begin
            model_acc = sum;
        end
    endfunction

    function automatic logic [31:0] model_reg(input logic [1:0] addr);
        case (addr)
            2'd0:    return model_acc;
            2'd1:    return {24'd0, sw};
            2'd2:    return {30'd0, model_ctrl};
            default: return {30'd0, model_press, model_ovf};
        endcase
    endfunction

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge CLK);
        avs_address   = addr;
        avs_write     = 1'b1;
        avs_writedata = data;
        @(negedge CLK);
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        case (addr)
            2'd0: model_acc = data & ((1 << AW) - 1);
            2'd2: model_ctrl = data[1:0];
            2'd3: begin
                if (data[0]) model_ovf = 1'b0;
                if (data[1]) model_press = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] expected, input string tag);
        @(negedge CLK);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge CLK);
        avs_read    = 1'b0;
        checkOutput({tag, " valid"}, {31'd0, avs_readdatavalid}, 32'd1);
        checkOutput({tag, " data"}, avs_readdata, expected);
    endtask

    task automatic checkAll(input string tag);
        bus_read(2'd0, model_reg(2'd0), {tag, " ACC"});
        bus_read(2'd3, model_reg(2'd3), {tag, " STATUS"});
        checkOutput({tag, " led"}, {24'd0, led}, {24'd0, model_ctrl[0] ? sw : model_acc[7:0]});
        checkOutput({tag, " irq"}, {31'd0, irq}, {31'd0, model_ctrl[1] & (model_press | model_ovf)});
    endtask

    task automatic applyStimulus(input logic [7:0] sw_val);
        @(negedge CLK);
        sw = sw_val;
        repeat (3) @(negedge CLK);
        key_n = 1'b0;
        repeat (10) @(negedge CLK);
        key_n = 1'b1;
        repeat (12) @(negedge CLK);
        model_add(sw_val);
    endtask

    initial begin
        bit found;

        // Reset state while RESET is held
        repeat (3) @(negedge CLK);
        checkOutput("reset rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
        checkOutput("reset rddata", avs_readdata, 32'd0);
        checkOutput("reset led", {24'd0, led}, 32'd0);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);
        RESET = 1'b0;
        model_reset();
        bus_read(2'd0, 32'd0, "reset ACC");
        bus_read(2'd2, 32'd0, "reset CTRL");
        bus_read(2'd3, 32'd0, "reset STATUS");

        // Single press with sw=0x05
        applyStimulus(8'h05);
        checkAll("press5");
        checkOutput("press5 led const", {24'd0, led}, 32'h05);

        // Randomized writes, clears and presses
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) bus_write(2'd0, $urandom());
            if ($urandom_range(0, 1) == 1) bus_write(2'd3, $urandom_range(0, 3));
            applyStimulus(8'($urandom_range(0, 255)));
            checkAll("rand");
        end

        // Bouncing key then held low: exactly one add
        bus_write(2'd3, 32'd3);
        @(negedge CLK);
        sw = 8'h22;
        repeat (3) @(negedge CLK);
        for (int b = 0; b < 4; b++) begin
            key_n = b[0];
            repeat (2) @(negedge CLK);
        end
        key_n = 1'b0;
        repeat (12) @(negedge CLK);
        key_n = 1'b1;
        repeat (12) @(negedge CLK);
        model_add(8'h22);
        checkAll("bounce");

        // Overflow: 0xFFFE + 3
        bus_write(2'd0, 32'h0000_FFFE);
        bus_write(2'd3, 32'd3);
        applyStimulus(8'h03);
        checkAll("overflow");

        // Bus write to ACC in the same cycle as the add pulse
        bus_write(2'd3, 32'd3);
        @(negedge CLK);
        sw = 8'h40;
        repeat (3) @(negedge CLK);
        key_n = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            if (dut.press_pulse === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("collide pulse seen", {31'd0, found}, 32'd1);
        if (found) begin
            avs_address   = 2'd0;
            avs_write     = 1'b1;
            avs_writedata = 32'h0000_1234;
            @(negedge CLK);
            avs_write     = 1'b0;
            avs_writedata = 32'd0;
        end
        model_acc   = 32'h1234;
        model_press = 1'b1;
        repeat (6) @(negedge CLK);
        key_n = 1'b1;
        repeat (12) @(negedge CLK);
        checkAll("collide");

        // Interrupt enable, press, then write-1-to-clear drops irq
        bus_write(2'd3, 32'd3);
        bus_write(2'd2, 32'd2);
        applyStimulus(8'h01);
        checkAll("irq set");
        @(negedge CLK);
        avs_address   = 2'd3;
        avs_write     = 1'b1;
        avs_writedata = 32'd3;
        @(negedge CLK);
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        model_ovf     = 1'b0;
        model_press   = 1'b0;
        @(negedge CLK);
        checkOutput("irq cleared", {31'd0, irq}, 32'd0);

        // LED sourced from switches
        bus_write(2'd2, 32'd1);
        @(negedge CLK);
        sw = 8'hA5;
        repeat (4) @(negedge CLK);
        checkOutput("led from sw", {24'd0, led}, 32'hA5);

        // Back-to-back reads of SW then CTRL
        @(negedge CLK);
        avs_address = 2'd1;
        avs_read    = 1'b1;
        @(negedge CLK);
        checkOutput("b2b SW valid", {31'd0, avs_readdatavalid}, 32'd1);
        checkOutput("b2b SW data", avs_readdata, model_reg(2'd1));
        avs_address = 2'd2;
        @(negedge CLK);
        avs_read = 1'b0;
        checkOutput("b2b CTRL valid", {31'd0, avs_readdatavalid}, 32'd1);
        checkOutput("b2b CTRL data", avs_readdata, model_reg(2'd2));
        @(negedge CLK);
        checkOutput("idle valid", {31'd0, avs_readdatavalid}, 32'd0);
        checkOutput("idle data", avs_readdata, 32'd0);

        // Reset asserted with a read in flight; key held through reset
        @(negedge CLK);
        avs_address = 2'd0;
        avs_read    = 1'b1;
        RESET       = 1'b1;
        key_n       = 1'b0;
        sw          = 8'h11;
        @(negedge CLK);
        avs_read = 1'b0;
        checkOutput("midreset valid", {31'd0, avs_readdatavalid}, 32'd0);
        checkOutput("midreset data", avs_readdata, 32'd0);
        checkOutput("midreset led", {24'd0, led}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        repeat (20) @(negedge CLK);
        key_n = 1'b1;
        repeat (12) @(negedge CLK);
        model_add(8'h11);
        checkAll("held through reset");
        bus_read(2'd2, model_reg(2'd2), "post reset CTRL");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
